// File: rtl/clock_pkg.sv
// clock_pkg
//   Shared types and constants for the starter-kit clock controller.
//   - ctrl_state_t : setting state machine encoding (also driven on LEDs)
//   - TIME_W       : width of the hour/minute/second counters
//   - HOUR_MAX, MIN_MAX, SEC_MAX : last legal value of each counter
//   - inc_wrap()   : increment with wrap to 0 at (or beyond) the limit
package clock_pkg;

    localparam int unsigned TIME_W = 6;

    localparam logic [TIME_W-1:0] HOUR_MAX = 6'd23;
    localparam logic [TIME_W-1:0] MIN_MAX  = 6'd59;
    localparam logic [TIME_W-1:0] SEC_MAX  = 6'd59;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } ctrl_state_t;

    // Values at or above the limit wrap to 0, so a corrupted counter
    // recovers on its next increment.
    function automatic logic [TIME_W-1:0] inc_wrap(
        input logic [TIME_W-1:0] val,
        input logic [TIME_W-1:0] lim
    );
        if (val >= lim) begin
            return '0;
        end
        return val + 1'b1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Free-running prescaler producing a one-cycle tick every CLK_HZ clocks.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset
//     clr   in  synchronous restart of the count at 0
//     tick  out high while the count sits at CLK_HZ-1
module tick_divider #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (clr || (tick_cnt == LAST)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/clock_time_controller.sv
// clock_time_controller
//   Keeps hours/minutes/seconds and sequences user setting of hours and
//   minutes from two debounced key pulses.
//   Ports:
//     clk        in  system clock
//     rst_n      in  asynchronous active-low reset
//     key_mode   in  pulse: RUN -> SET_HOUR -> SET_MIN -> RUN
//     key_inc    in  pulse: increment edited field / toggle display in RUN
//     hour       out 0..23
//     min        out 0..59
//     sec        out 0..59
//     min_or_sec out display select, 0 = hour:min, 1 = min:sec
//     blink      out field-visible strobe, toggles per tick while setting
//     setting    out current state encoding
module clock_time_controller
    import clock_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_mode,
    input  logic              key_inc,
    output logic [TIME_W-1:0] hour,
    output logic [TIME_W-1:0] min,
    output logic [TIME_W-1:0] sec,
    output logic              min_or_sec,
    output logic              blink,
    output logic [1:0]        setting
);

    ctrl_state_t       state, state_nx;
    logic [TIME_W-1:0] hour_nx, min_nx, sec_nx;
    logic              mos_nx, blink_nx;
    logic              tick, tick_clr;

    tick_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        state_nx = state;
        hour_nx  = hour;
        min_nx   = min;
        sec_nx   = sec;
        mos_nx   = min_or_sec;
        blink_nx = blink;
        tick_clr = 1'b0;

        case (state)
            RUN: begin
                blink_nx = 1'b1;
                // Carry chain resolves fully within one edge.
                if (tick) begin
                    sec_nx = inc_wrap(sec, SEC_MAX);
                    if (sec >= SEC_MAX) begin
                        min_nx = inc_wrap(min, MIN_MAX);
                        if (min >= MIN_MAX) begin
                            hour_nx = inc_wrap(hour, HOUR_MAX);
                        end
                    end
                end
                if (key_mode) begin
                    state_nx = SET_HOUR;
                    mos_nx   = 1'b0;
                end else if (key_inc) begin
                    mos_nx = ~min_or_sec;
                end
            end

            SET_HOUR: begin
                mos_nx = 1'b0;
                if (key_mode) begin
                    state_nx = SET_MIN;
                    blink_nx = 1'b1;
                end else begin
                    if (key_inc) begin
                        hour_nx = inc_wrap(hour, HOUR_MAX);
                    end
                    if (tick) begin
                        blink_nx = ~blink;
                    end
                end
            end

            SET_MIN: begin
                mos_nx = 1'b0;
                if (key_mode) begin
                    // Restart the second so the first one after setting
                    // lasts a full CLK_HZ cycles.
                    state_nx = RUN;
                    sec_nx   = '0;
                    blink_nx = 1'b1;
                    tick_clr = 1'b1;
                end else begin
                    if (key_inc) begin
                        min_nx = inc_wrap(min, MIN_MAX);
                    end
                    if (tick) begin
                        blink_nx = ~blink;
                    end
                end
            end

            default: begin
                state_nx = RUN;
                mos_nx   = 1'b0;
                blink_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            hour       <= '0;
            min        <= '0;
            sec        <= '0;
            min_or_sec <= 1'b0;
            blink      <= 1'b1;
        end else begin
            state      <= state_nx;
            hour       <= hour_nx;
            min        <= min_nx;
            sec        <= sec_nx;
            min_or_sec <= mos_nx;
            blink      <= blink_nx;
        end
    end

    assign setting = state;

endmodule

// File: tb/tb_clock_time_controller.sv
module tb_clock_time_controller;

    typedef struct {
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       mos;
        logic       bl;
        logic       chk_bl;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        logic km;
        logic ki;
        exp_t e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       key_mode;
    logic       key_inc;
    logic [5:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       min_or_sec;
    logic       blink;
    logic [1:0] setting;

    int unsigned vectors;
    int unsigned miscompares;
    exp_t        sb_q[$];
    vec_t        tbl[26];

    clock_time_controller #(
        .CLK_HZ (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_mode   (key_mode),
        .key_inc    (key_inc),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .min_or_sec (min_or_sec),
        .blink      (blink),
        .setting    (setting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int h, input int m, input int s,
                                input int mos, input int bl, input int st,
                                input bit chk_bl = 1'b1);
        exp_t e;
        e.h      = 6'(h);
        e.m      = 6'(m);
        e.s      = 6'(s);
        e.mos    = 1'(mos);
        e.bl     = 1'(bl);
        e.chk_bl = chk_bl;
        e.st     = 2'(st);
        return e;
    endfunction

    function automatic vec_t mv(input int km, input int ki, input int h,
                                input int m, input int s, input int mos,
                                input int bl, input int st);
        vec_t v;
        v.km = 1'(km);
        v.ki = 1'(ki);
        v.e  = mk(h, m, s, mos, bl, st);
        return v;
    endfunction

    task automatic check(input string name, input exp_t e);
        vectors++;
        if (hour !== e.h || min !== e.m || sec !== e.s || min_or_sec !== e.mos ||
            setting !== e.st || (e.chk_bl && blink !== e.bl)) begin
            miscompares++;
            $display("FAIL %s: got %0d:%0d:%0d mos=%b blink=%b set=%0d, want %0d:%0d:%0d mos=%b blink=%b set=%0d",
                     name, hour, min, sec, min_or_sec, blink, setting,
                     e.h, e.m, e.s, e.mos, e.chk_bl ? e.bl : 1'bx, e.st);
        end
    endtask

    // Expected result queued as the stimulus goes out, retired after the edge.
    task automatic drive(input logic km, input logic ki, input exp_t e, input string name);
        sb_q.push_back(e);
        key_mode = km;
        key_inc  = ki;
        @(posedge clk);
        #1;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, sb_q.pop_front());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        key_mode    = 1'b0;
        key_inc     = 1'b0;

        // Continues from 00:01:00 with the prescaler at 0 after edge 240.
        tbl[0]  = mv(0,1, 0,1,0, 1,1,0);
        tbl[1]  = mv(0,1, 0,1,0, 0,1,0);
        tbl[2]  = mv(0,0, 0,1,0, 0,1,0);
        tbl[3]  = mv(0,1, 0,1,1, 1,1,0);  // tick and key_inc together
        tbl[4]  = mv(1,1, 0,1,1, 0,1,1);  // key_mode wins over key_inc
        tbl[5]  = mv(0,1, 1,1,1, 0,1,1);
        tbl[6]  = mv(0,0, 1,1,1, 0,1,1);
        tbl[7]  = mv(0,0, 1,1,1, 0,0,1);  // tick frozen, blink toggles
        tbl[8]  = mv(0,1, 2,1,1, 0,0,1);
        tbl[9]  = mv(0,0, 2,1,1, 0,0,1);
        tbl[10] = mv(0,0, 2,1,1, 0,0,1);
        tbl[11] = mv(0,0, 2,1,1, 0,1,1);
        tbl[12] = mv(1,0, 2,1,1, 0,1,2);
        tbl[13] = mv(0,1, 2,2,1, 0,1,2);
        tbl[14] = mv(0,0, 2,2,1, 0,1,2);
        tbl[15] = mv(1,0, 2,2,0, 0,1,0);  // leave SET_MIN on a tick cycle
        tbl[16] = mv(0,0, 2,2,0, 0,1,0);
        tbl[17] = mv(0,0, 2,2,0, 0,1,0);
        tbl[18] = mv(0,0, 2,2,0, 0,1,0);
        tbl[19] = mv(0,0, 2,2,1, 0,1,0);  // full second after restart
        tbl[20] = mv(0,0, 2,2,1, 0,1,0);
        tbl[21] = mv(0,0, 2,2,1, 0,1,0);
        tbl[22] = mv(0,0, 2,2,1, 0,1,0);
        tbl[23] = mv(1,0, 2,2,2, 0,1,1);  // tick still applies on RUN exit
        tbl[24] = mv(1,0, 2,2,2, 0,1,2);
        tbl[25] = mv(1,0, 2,2,0, 0,1,0);

        repeat (3) @(posedge clk);
        #1;
        check("reset", mk(0,0,0,0,1,0));
        rst_n = 1'b1;

        for (int c = 1; c <= 240; c++) begin
            drive(1'b0, 1'b0, mk(0, c / 240, (c / 4) % 60, 0, 1, 0), "run240");
        end

        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].km, tbl[i].ki, tbl[i].e, $sformatf("tbl%0d", i));
        end

        // Asynchronous reset while in SET_MIN.
        drive(1'b1, 1'b0, mk(2,2,0,0,1,1), "rst_pre_hour");
        drive(1'b1, 1'b0, mk(2,2,0,0,1,2), "rst_pre_min");
        drive(1'b0, 1'b1, mk(2,3,0,0,1,2), "rst_pre_inc");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(0,0,0,0,1,0));
        @(posedge clk);
        #1;
        check("reset_held", mk(0,0,0,0,1,0));
        rst_n = 1'b1;

        // Hour wrap and frozen counters while setting.
        drive(1'b1, 1'b0, mk(0,0,0,0,1,1), "enter_hour");
        for (int i = 1; i <= 25; i++) begin
            drive(1'b0, 1'b1, mk(i % 24, 0, 0, 0, 0, 1, 1'b0), "hour_inc");
        end
        drive(1'b1, 1'b0, mk(1,0,0,0,1,2), "enter_min");
        for (int i = 1; i <= 61; i++) begin
            drive(1'b0, 1'b1, mk(1, i % 60, 0, 0, 0, 2, 1'b0), "min_inc");
        end
        drive(1'b1, 1'b0, mk(1,1,0,0,1,0), "exit_set");
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b0, mk(1, 1, (k == 4) ? 1 : 0, 0, 1, 0), "first_sec");
        end

        // Preload 23:59 and roll over to midnight.
        drive(1'b1, 1'b0, mk(1,1,1,0,1,1), "pre_hour");
        for (int i = 1; i <= 22; i++) begin
            drive(1'b0, 1'b1, mk(1 + i, 1, 1, 0, 0, 1, 1'b0), "pre_hour_inc");
        end
        drive(1'b1, 1'b0, mk(23,1,1,0,1,2), "pre_min");
        for (int i = 1; i <= 58; i++) begin
            drive(1'b0, 1'b1, mk(23, 1 + i, 1, 0, 0, 2, 1'b0), "pre_min_inc");
        end
        drive(1'b1, 1'b0, mk(23,59,0,0,1,0), "pre_run");
        for (int k = 1; k <= 240; k++) begin
            if (k < 240) begin
                drive(1'b0, 1'b0, mk(23, 59, k / 4, 0, 1, 0), "to_midnight");
            end else begin
                drive(1'b0, 1'b0, mk(0, 0, 0, 0, 1, 0), "midnight");
            end
        end

        // Blink sequence across three ticks in SET_HOUR.
        drive(1'b1, 1'b0, mk(0,0,0,0,1,1), "blink_entry");
        for (int k = 242; k <= 252; k++) begin
            drive(1'b0, 1'b0, mk(0, 0, 0, 0, (((k - 240) / 4) % 2 == 0) ? 1 : 0, 1), "blink_seq");
        end
        drive(1'b1, 1'b0, mk(0,0,0,0,1,2), "blink_min_entry");
        drive(1'b1, 1'b0, mk(0,0,0,0,1,0), "blink_run");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_time_controller.md
# clock_time_controller

Timekeeping and time-setting controller for the starter-kit clock. It keeps the hour/minute/second counters and sequences user setting of hours and minutes from two pre-debounced key pulses. It drives `hour`, `min`, `sec` and `min_or_sec` straight into the time-to-number display converter, plus a `blink` strobe that the display path uses to flash the field being edited.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency. The internal 1 Hz tick fires every `CLK_HZ` cycles. Minimum value is 2.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_mode`  in  1  single-cycle pulse, debounced upstream. Advances the setting state.
- `key_inc`  in  1  single-cycle pulse, debounced upstream. Increments the edited field, or toggles the display mode in RUN.
- `hour`  out  6  hours, 0..23.
- `min`  out  6  minutes, 0..59.
- `sec`  out  6  seconds, 0..59.
- `min_or_sec`  out  1  display select. 0 = hour:min, 1 = min:sec.
- `blink`  out  1  field-visible strobe.
- `setting`  out  2  current state encoding, for LEDs.

One clock, `clk`. Reset `rst_n` is asynchronous and active-low.

## Operation
- States:
  - RUN (2'd0)
  - SET_HOUR (2'd1)
  - SET_MIN (2'd2)
  - 2'd3 is illegal and recovers to RUN on the next edge.
- Transitions on `key_mode`: RUN → SET_HOUR → SET_MIN → RUN.
- Prescaler:
  - `tick_cnt` counts 0..CLK_HZ-1 continuously in all states.
  - `tick` = (`tick_cnt` == CLK_HZ-1).
- RUN:
  - On `tick`, `sec` increments.
  - Wrap 59 → 0 carries into `min`; `min` wrap 59 → 0 carries into `hour`; `hour` wraps 23 → 0. Full carry happens in the same edge.
  - `key_inc` toggles `min_or_sec`.
- SET_HOUR:
  - Counters are frozen; `tick` is ignored.
  - `key_inc` increments `hour`, wrapping 23 → 0.
  - `min_or_sec` is forced to 0 so hour:min is shown.
- SET_MIN:
  - Counters are frozen.
  - `key_inc` increments `min`, wrapping 59 → 0.
  - `min_or_sec` is held at 0.
- Leaving SET_MIN for RUN:
  - `sec` is cleared to 0 and `tick_cnt` is cleared to 0, so the first second after setting is a full second.
  - `min_or_sec` stays 0.
- `blink`:
  - 1 in RUN.
  - In SET states it toggles on every `tick`.
  - Forced to 1 on entry to SET_HOUR and on entry to SET_MIN.
- Simultaneous events:
  - `key_mode` and `key_inc` in the same cycle: `key_mode` wins, `key_inc` is dropped.
  - `tick` and `key_inc` in RUN: both take effect in that edge.
  - `tick` and `key_mode` (RUN → SET_HOUR): the tick increment still applies in that edge.
- Arithmetic: all counters are 6-bit unsigned and never exceed their range. Out-of-range values are unreachable; if one occurs, the counter wraps to 0 on its next increment.

## Timing
- Reset values: `hour`=0, `min`=0, `sec`=0, `min_or_sec`=0, `blink`=1, `setting`=2'd0, `tick_cnt`=0.
- All outputs are registered. A key pulse sampled at edge N is visible after edge N; latency is 1 cycle.
- First `tick` after reset is at cycle CLK_HZ-1, so `sec`=1 after edge CLK_HZ.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Deassertion is synchronised upstream.
- No handshake. Keys are fire-and-forget pulses; a pulse held high for k cycles counts as k events.

## Structure
- Package `clock_pkg`:
  - typedef enum logic [1:0] `ctrl_state_t` {RUN, SET_HOUR, SET_MIN}.
  - Constants `HOUR_MAX`=23, `MIN_MAX`=59, `SEC_MAX`=59, `TIME_W`=6.
- Sub-module `tick_divider` (params `CLK_HZ`; ports `clk`, `rst_n`, `clr`, `tick`) holds the prescaler. The controller drives `clr` when leaving SET_MIN.
- The state register and counters live in a single `always_ff`; next-state logic lives in `always_comb`.

## Test plan
- Reset, CLK_HZ=4, run 240 cycles → `sec`=0→59 then 0, `min`=1; `hour`/`min` carry verified at 23:59:59 preload (via setting) → 00:00:00 on the next tick.
- `key_mode` then 25×`key_inc` → `setting`=1, `hour`=1 (wrap 23 → 0), `min_or_sec`=0, counters frozen across ticks.
- `key_mode`×2, `key_inc`×61 → `min`=1; third `key_mode` → `setting`=0, `sec`=0, next `sec`=1 exactly CLK_HZ cycles later.
- RUN, `key_inc` → `min_or_sec`=1; same cycle as `key_mode` → state advances, `hour` unchanged.
- SET_HOUR for 3 ticks → `blink` sequence 1, 0, 1, 0; RUN → `blink`=1.
- Assert `rst_n`=0 mid-SET_MIN between edges → all outputs at reset values before the next edge.
